// File: rtl/race_state_ctrl.sv
// race_state_ctrl: game-flow sequencer for the car-racing display pipeline.
// Runs IDLE/COUNTDOWN/RACE/CRASH/WIN/OVER, counts frames, tracks lives and
// race progress, and drives the compositor layer enables. All outputs are
// registered and reflect the new state one clock after the triggering event.
// Optional feature macro: RACE_PAUSE_EN (adds the PAUSE state on pause_btn).
module race_state_ctrl #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int RACE_FRAMES      = 3600,
  parameter int CRASH_FRAMES     = 120,
  parameter int START_LIVES      = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        collision,
  input  logic        pause_btn,
  output logic [2:0]  state,
  output logic        cars_run,
  output logic        player_en,
  output logic        win_overlay,
  output logic [1:0]  lives,
  output logic [11:0] progress
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_RACE  = 3'd2,
    S_CRASH = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  // Frame counts must fit the 12-bit frame counter and lives the 2-bit field.
  if ((COUNTDOWN_FRAMES < 1) || (COUNTDOWN_FRAMES > 4095) ||
      (RACE_FRAMES < 1) || (RACE_FRAMES > 4095) ||
      (CRASH_FRAMES < 1) || (CRASH_FRAMES > 4095) ||
      (START_LIVES < 1) || (START_LIVES > 3)) begin : g_bad_params
    $error("race_state_ctrl: parameter out of range");
  end

  localparam logic [11:0] CD_LAST    = 12'(COUNTDOWN_FRAMES - 1);
  localparam logic [11:0] CR_LAST    = 12'(CRASH_FRAMES - 1);
  localparam logic [11:0] RACE_END   = 12'(RACE_FRAMES);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);

  state_t      state_q, state_d;
  logic [11:0] fcnt_q, fcnt_d;
  logic [1:0]  lives_q, lives_d;
  logic [11:0] progress_q, progress_d;
  logic        start_q;
  logic        cars_run_q, cars_run_d;
  logic        player_en_q, player_en_d;
  logic        win_q, win_d;
  logic        start_rise_s;
  logic        pause_rise_s;
  logic        keep_fcnt_s;
  logic [11:0] prog_inc_s;

  assign start_rise_s = start_btn & ~start_q;
  assign prog_inc_s   = progress_q + 12'd1;

`ifdef RACE_PAUSE_EN
  logic   pause_q;
  state_t ret_q, ret_d;

  assign pause_rise_s = pause_btn & ~pause_q;
  // Entering, leaving or sitting in PAUSE keeps the frame count frozen.
  assign keep_fcnt_s  = (state_d == S_PAUSE) || (state_q == S_PAUSE);

  // Remember where to resume when a pause is requested.
  always_comb begin
    ret_d = ret_q;
    if ((state_d == S_PAUSE) && (state_q != S_PAUSE)) begin
      ret_d = state_q;
    end else begin
      ret_d = ret_q;
    end
  end

  // Pause edge detector and return-state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pause_q <= 1'b1;
      ret_q   <= S_IDLE;
    end else begin
      pause_q <= pause_btn;
      ret_q   <= ret_d;
    end
  end
`else
  logic unused_pause_s;
  assign unused_pause_s = pause_btn;
  assign pause_rise_s   = 1'b0;
  assign keep_fcnt_s    = 1'b0;
`endif

  // State register together with the frame/lives/progress datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fcnt_q     <= 12'd0;
      lives_q    <= 2'd0;
      progress_q <= 12'd0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      lives_q    <= lives_d;
      progress_q <= progress_d;
      start_q    <= start_btn;
    end
  end

  // Next-state decision; pause requests take priority over frame events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise_s) state_d = S_COUNT;
        else              state_d = state_q;
      end
      S_COUNT: begin
        if (pause_rise_s)                           state_d = S_PAUSE;
        else if (frame_tick && (fcnt_q == CD_LAST)) state_d = S_RACE;
        else                                        state_d = state_q;
      end
      S_RACE: begin
        if (pause_rise_s)                  state_d = S_PAUSE;
        else if (frame_tick && collision)  state_d = S_CRASH;
        else if (frame_tick && (prog_inc_s == RACE_END)) state_d = S_WIN;
        else                               state_d = state_q;
      end
      S_CRASH: begin
        if (frame_tick && (fcnt_q == CR_LAST)) begin
          if (lives_q == 2'd0) state_d = S_OVER;
          else                 state_d = S_COUNT;
        end else begin
          state_d = state_q;
        end
      end
      S_WIN, S_OVER: begin
        if (start_rise_s) state_d = S_IDLE;
        else              state_d = state_q;
      end
`ifdef RACE_PAUSE_EN
      S_PAUSE: begin
        if (pause_rise_s) state_d = ret_q;
        else              state_d = state_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counter, lives and progress updates for the current cycle.
  always_comb begin
    fcnt_d     = fcnt_q;
    lives_d    = lives_q;
    progress_d = progress_q;

    if (keep_fcnt_s)                fcnt_d = fcnt_q;
    else if (state_d != state_q)    fcnt_d = 12'd0;
    else if (frame_tick)            fcnt_d = fcnt_q + 12'd1;
    else                            fcnt_d = fcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          lives_d    = LIVES_INIT;
          progress_d = 12'd0;
        end else begin
          lives_d    = lives_q;
          progress_d = progress_q;
        end
      end
      S_RACE: begin
        if (!pause_rise_s && frame_tick && collision) begin
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          else                 lives_d = lives_q;
        end else if (!pause_rise_s && frame_tick && (progress_q < RACE_END)) begin
          progress_d = prog_inc_s;
        end else begin
          progress_d = progress_q;
        end
      end
      S_WIN, S_OVER: begin
        if (start_rise_s) begin
          lives_d    = 2'd0;
          progress_d = 12'd0;
        end else begin
          lives_d    = lives_q;
          progress_d = progress_q;
        end
      end
      default: begin
        lives_d    = lives_q;
        progress_d = progress_q;
      end
    endcase
  end

  // Layer controls derived from the state being entered; the crash flash
  // follows bit 3 of the frame count so the player blinks every 8 frames.
  always_comb begin
    cars_run_d  = (state_d == S_RACE);
    win_d       = (state_d == S_WIN);
    player_en_d = 1'b1;
    case (state_d)
      S_IDLE, S_OVER: player_en_d = 1'b0;
      S_CRASH:        player_en_d = ~fcnt_d[3];
      default:        player_en_d = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cars_run_q  <= 1'b0;
      player_en_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      cars_run_q  <= cars_run_d;
      player_en_q <= player_en_d;
      win_q       <= win_d;
    end
  end

  assign state       = state_q;
  assign cars_run    = cars_run_q;
  assign player_en   = player_en_q;
  assign win_overlay = win_q;
  assign lives       = lives_q;
  assign progress    = progress_q;

endmodule

// File: tb/tb_race_state_ctrl.sv
// Directed bench for race_state_ctrl with small frame counts
// (COUNTDOWN=3, RACE=5, CRASH=2, START_LIVES=2).
module tb_race_state_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        collision = 1'b0;
  logic        pause_btn = 1'b0;
  logic [2:0]  state;
  logic        cars_run;
  logic        player_en;
  logic        win_overlay;
  logic [1:0]  lives;
  logic [11:0] progress;

  int n_checks = 0;
  int n_fail   = 0;

  race_state_ctrl #(
    .COUNTDOWN_FRAMES(3),
    .RACE_FRAMES(5),
    .CRASH_FRAMES(2),
    .START_LIVES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .collision(collision),
    .pause_btn(pause_btn),
    .state(state),
    .cars_run(cars_run),
    .player_en(player_en),
    .win_overlay(win_overlay),
    .lives(lives),
    .progress(progress)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic col);
    frame_tick = 1'b1;
    collision  = col;
    cyc();
    frame_tick = 1'b0;
    collision  = 1'b0;
  endtask

  task automatic start_pulse();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  task automatic pause_pulse();
    pause_btn = 1'b1;
    cyc();
    pause_btn = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset with start held, then release: must stay IDLE.
    reset_n   = 1'b0;
    start_btn = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (2) cyc();
    check("held_start_state", 12'(state), 12'd0);
    start_btn = 1'b0;
    cyc();
    check("rst_state", 12'(state), 12'd0);
    check("rst_cars_run", 12'(cars_run), 12'd0);
    check("rst_player_en", 12'(player_en), 12'd0);
    check("rst_win", 12'(win_overlay), 12'd0);
    check("rst_lives", 12'(lives), 12'd0);
    check("rst_progress", progress, 12'd0);

    // Game 1: clean run to WIN.
    start_pulse();
    check("g1_countdown", 12'(state), 12'd1);
    check("g1_lives", 12'(lives), 12'd2);
    check("g1_player_en", 12'(player_en), 12'd1);
    tick(1'b0);
    tick(1'b0);
    check("g1_cd_2ticks", 12'(state), 12'd1);
    tick(1'b0);
    check("g1_race", 12'(state), 12'd2);
    check("g1_cars_run", 12'(cars_run), 12'd1);
    repeat (4) tick(1'b0);
    check("g1_prog4", progress, 12'd4);
    check("g1_still_race", 12'(state), 12'd2);
    tick(1'b0);
    check("g1_win", 12'(state), 12'd4);
    check("g1_win_overlay", 12'(win_overlay), 12'd1);
    check("g1_win_prog", progress, 12'd5);
    check("g1_win_lives", 12'(lives), 12'd2);
    check("g1_win_cars", 12'(cars_run), 12'd0);
    tick(1'b1);
    check("g1_win_hold", 12'(state), 12'd4);
    check("g1_win_hold_prog", progress, 12'd5);
    start_pulse();
    check("g1_idle", 12'(state), 12'd0);
    check("g1_idle_lives", 12'(lives), 12'd0);
    check("g1_idle_prog", progress, 12'd0);
    check("g1_idle_win", 12'(win_overlay), 12'd0);

    // Game 2: crash at progress 2, restart countdown keeping progress.
    start_pulse();
    repeat (3) tick(1'b0);
    check("g2_race", 12'(state), 12'd2);
    repeat (2) tick(1'b0);
    check("g2_prog2", progress, 12'd2);
    tick(1'b1);
    check("g2_crash", 12'(state), 12'd3);
    check("g2_crash_lives", 12'(lives), 12'd1);
    check("g2_crash_cars", 12'(cars_run), 12'd0);
    check("g2_crash_prog", progress, 12'd2);
    start_pulse();
    check("g2_crash_ignores_start", 12'(state), 12'd3);
    tick(1'b0);
    check("g2_crash_1tick", 12'(state), 12'd3);
    tick(1'b0);
    check("g2_back_countdown", 12'(state), 12'd1);
    check("g2_cd_prog", progress, 12'd2);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("g2_race_again", 12'(state), 12'd2);
    check("g2_cd_collision_ignored", 12'(lives), 12'd1);
    repeat (2) tick(1'b0);
    check("g2_prog4", progress, 12'd4);
    // Collision on the finishing tick wins over finishing.
    tick(1'b1);
    check("g2_finish_crash", 12'(state), 12'd3);
    check("g2_finish_prog", progress, 12'd4);
    check("g2_lives0", 12'(lives), 12'd0);
    repeat (2) tick(1'b0);
    check("g2_over", 12'(state), 12'd5);
    check("g2_over_player", 12'(player_en), 12'd0);
    start_pulse();
    check("g2_idle", 12'(state), 12'd0);
    check("g2_idle_lives", 12'(lives), 12'd0);
    check("g2_idle_prog", progress, 12'd0);

    // Reset in the middle of a game.
    start_pulse();
    tick(1'b0);
    check("mid_countdown", 12'(state), 12'd1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("mid_reset_state", 12'(state), 12'd0);
    check("mid_reset_lives", 12'(lives), 12'd0);
    check("mid_reset_player", 12'(player_en), 12'd0);
    cyc();

`ifdef RACE_PAUSE_EN
    // Pause in RACE freezes progress and lives.
    start_pulse();
    repeat (3) tick(1'b0);
    tick(1'b0);
    check("p_prog1", progress, 12'd1);
    pause_pulse();
    check("p_pause", 12'(state), 12'd6);
    check("p_cars", 12'(cars_run), 12'd0);
    repeat (10) tick(1'b1);
    check("p_frozen_prog", progress, 12'd1);
    check("p_frozen_lives", 12'(lives), 12'd2);
    check("p_still_pause", 12'(state), 12'd6);
    pause_pulse();
    check("p_resume", 12'(state), 12'd2);
    tick(1'b0);
    check("p_resume_prog", progress, 12'd2);
`else
    // Without pause support pause_btn has no effect.
    start_pulse();
    repeat (3) tick(1'b0);
    pause_pulse();
    check("np_no_pause", 12'(state), 12'd2);
    tick(1'b0);
    check("np_prog", progress, 12'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
